// File: rtl/serv_seq_ctrl.sv
// Instruction-cycle sequencer for the bit-serial core.
// Runs each instruction through fetch, decode, an optional init pass,
// an optional memory or shift wait, and the execute pass.
// It also drives the serial bit counter, and it is the only block that enables that counter.
// W is the datapath width per cycle and must be 1 or 4.
// Each serial pass therefore lasts 32/W cycles.
module serv_seq_ctrl #(
    parameter int W = 1
) (
    input  logic       clk,
    input  logic       i_rst,
    output logic       o_ibus_cyc,
    input  logic       i_ibus_ack,
    output logic       o_dec_en,
    input  logic       i_two_stage,
    input  logic       i_mem_op,
    input  logic       i_shift_op,
    input  logic       i_sh_done,
    output logic       o_dbus_cyc,
    input  logic       i_dbus_ack,
    output logic       o_init,
    output logic       o_cnt_en,
    output logic [4:0] o_cnt,
    output logic       o_cnt_done,
    output logic       o_run
);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        DECODE,
        INIT,
        MEM,
        SHIFT,
        RUN
    } state_t;

    localparam logic [4:0] CNT_STEP = 5'(W);
    localparam logic [4:0] CNT_LAST = 5'(32 - W);

    state_t     state_q, state_d;
    logic [4:0] cnt_q, cnt_d;

    // State register and bit counter.
    // Asynchronous reset returns the block to IDLE and clears the counter.
    // NOTE: sequential state uses non-blocking assignments only, so every flop
    // samples the pre-edge value of every other flop regardless of block order.
    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic and Moore/Mealy outputs.
    // Acks are looked at only in the state that owns the matching request.
    // NOTE: every signal written here gets a default first.
    // That way no path through the case statement can leave a value unassigned and infer a latch.
    always_comb begin
        state_d    = state_q;
        o_ibus_cyc = 1'b0;
        o_dec_en   = 1'b0;
        o_dbus_cyc = 1'b0;
        o_init     = 1'b0;
        o_cnt_en   = 1'b0;
        o_run      = 1'b0;

        unique case (state_q)
            IDLE: begin
                state_d = FETCH;
            end
            FETCH: begin
                o_ibus_cyc = 1'b1;
                // A zero-wait slave may ack in the same cycle as the request.
                if (i_ibus_ack) begin
                    o_dec_en = 1'b1;
                    state_d  = DECODE;
                end
            end
            DECODE: begin
                // One cycle so the decoder outputs settle before being used.
                state_d = i_two_stage ? INIT : RUN;
            end
            INIT: begin
                o_init   = 1'b1;
                o_cnt_en = 1'b1;
                if (cnt_q == CNT_LAST) begin
                    if (i_mem_op)        state_d = MEM;
                    else if (i_shift_op) state_d = SHIFT;
                    else                 state_d = RUN;
                end
            end
            MEM: begin
                o_dbus_cyc = 1'b1;
                if (i_dbus_ack) state_d = RUN;
            end
            SHIFT: begin
                if (i_sh_done) state_d = RUN;
            end
            RUN: begin
                o_run    = 1'b1;
                o_cnt_en = 1'b1;
                if (cnt_q == CNT_LAST) state_d = FETCH;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // The counter advances only while a pass is running.
    // A full pass wraps the counter back to 0, so every pass starts at bit 0 without an explicit clear.
    // While the block waits in MEM or SHIFT, the counter stays frozen at 0.
    always_comb begin
        cnt_d = o_cnt_en ? cnt_q + CNT_STEP : cnt_q;
    end

    assign o_cnt      = cnt_q;
    assign o_cnt_done = o_cnt_en & (cnt_q == CNT_LAST);

endmodule

// File: doc/serv_seq_ctrl.md
Name: serv_seq_ctrl

Overview:
Instruction-cycle sequencer for the bit-serial core. Owns the fetch handshake, loads the instruction decoder and drives the serial bit counter. Steps each instruction through fetch, decode, optional init pass, optional memory/shift wait and the execute pass. It sits between the ibus/dbus interfaces and the decoder/ALU/bufreg datapath, and is the only block that enables the counter.

Parameters:
W, 1, datapath bits per cycle; legal values 1 or 4. Each serial pass lasts 32/W cycles.

Ports:
clk  in  1  clock
i_rst  in  1  asynchronous active-high reset
o_ibus_cyc  out  1  instruction fetch request
i_ibus_ack  in  1  fetch acknowledge; instruction word valid this cycle
o_dec_en  out  1  load strobe to decoder; equals i_ibus_ack & (state==FETCH)
i_two_stage  in  1  decoded instruction needs init pass (branch, jal/jalr, load/store, shift, slt)
i_mem_op  in  1  decoded load/store
i_shift_op  in  1  decoded shift
i_sh_done  in  1  shifter finished
o_dbus_cyc  out  1  data bus request
i_dbus_ack  in  1  data bus acknowledge
o_init  out  1  init pass active
o_cnt_en  out  1  serial counter running
o_cnt  out  5  bit position of current pass
o_cnt_done  out  1  last cycle of a pass
o_run  out  1  execute pass active; enables rd write and PC update

Behaviour:
- Clock and reset: single clock clk. Asynchronous active-high reset i_rst.
- Reset values: state=IDLE, counter=0. All outputs are 0 during reset.
- States and transitions:
  - IDLE -> FETCH on the first clk edge with i_rst low.
  - FETCH: o_ibus_cyc=1. Hold until i_ibus_ack. On ack, o_dec_en=1 in the same cycle and next state is DECODE.
  - DECODE: exactly one cycle, so the decoder outputs settle. If i_two_stage, go to INIT; otherwise go to RUN.
  - INIT: o_init=1, o_cnt_en=1, lasting 32/W cycles. On o_cnt_done: i_mem_op -> MEM; else i_shift_op -> SHIFT; else RUN.
  - MEM: o_dbus_cyc=1. Hold until i_dbus_ack, then RUN. The counter is frozen.
  - SHIFT: hold until i_sh_done, then RUN. The counter is frozen.
  - RUN: o_run=1, o_cnt_en=1, lasting 32/W cycles. On o_cnt_done -> FETCH.
- Counter:
  - Advances by W on each cycle with o_cnt_en; 5-bit arithmetic, wraps modulo 32.
  - Equals 0 at the start of every pass.
  - o_cnt_done = o_cnt_en & (o_cnt == 32-W).
- Ack handling:
  - i_ibus_ack outside FETCH and i_dbus_ack outside MEM are ignored.
  - o_dec_en never pulses outside FETCH.
  - Ack in the same cycle the request is raised is accepted (zero-wait slave).
- Sampling of inputs:
  - i_sh_done in SHIFT is sampled each cycle. If already high on entry, SHIFT lasts exactly one cycle.
  - i_two_stage, i_mem_op and i_shift_op are sampled only at DECODE exit and INIT completion. Changes elsewhere have no effect.
- Reset mid-operation: any state returns immediately to IDLE and the counter clears. Pending bus requests drop asynchronously, with no partial ack handling.
- Flow is strictly one instruction at a time; there is no overlap of fetch and execute.

Test Plan:
- Reset release, ibus acks 2 cycles after o_ibus_cyc rises, i_two_stage=0, W=1:
  - o_dec_en pulses once on the ack cycle (t).
  - DECODE at t+1; o_run high t+2..t+33; o_cnt_done at t+33 with o_cnt=31.
  - o_ibus_cyc high again at t+34.
- Load with i_two_stage=1, i_mem_op=1, dbus ack 3 cycles after o_dbus_cyc:
  - o_init for 32 cycles.
  - o_dbus_cyc for 4 cycles with o_cnt frozen at 0.
  - o_run for 32 cycles, then fetch.
- Shift, i_two_stage=1, i_shift_op=1: i_sh_done already high -> SHIFT lasts 1 cycle. i_sh_done delayed 10 cycles -> RUN starts 10 cycles later.
- W=4, single-stage instruction: o_run lasts 8 cycles, o_cnt steps 0,4,...,28, and o_cnt_done coincides with o_cnt=28.
- Spurious i_ibus_ack during RUN and spurious i_dbus_ack during INIT: no o_dec_en pulse, and no state or counter change.
- Assert i_rst at o_cnt=17 during RUN: outputs are 0 asynchronously. After release, IDLE then FETCH, and the first pass starts at o_cnt=0.
